// File: rtl/adc_serial_pkg.sv
// Shared definitions for the ADC configuration-link receiver:
// FSM state encoding, word field positions and a saturating counter helper.
package adc_serial_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        COMMIT    = 2'd3
    } rx_state_t;

    localparam int WORD_BITS = 32;
    localparam int HDR_LSB   = 20;
    localparam int ADDR_MSB  = 19;
    localparam int ADDR_LSB  = 16;
    localparam int DATA_MSB  = 15;
    localparam int CNT_BITS  = 5;

    // Increment an 8-bit count, holding at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/adc_serial_receiver_sync_edge_detect.sv
// sync_edge_detect: N-flop synchroniser for an asynchronous input followed by
// one history flop, giving a synchronised level and a one-cycle rising-edge flag.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise
);

    logic [STAGES-1:0] chain_r;
    logic              hist_r;

    // Synchroniser chain plus history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= '0;
            hist_r  <= 1'b0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], din};
            hist_r  <= chain_r[STAGES-1];
        end
    end

    assign sync = chain_r[STAGES-1];
    assign rise = chain_r[STAGES-1] & ~hist_r;

endmodule

// File: rtl/adc_serial_receiver.sv
// adc_serial_receiver: oversampling receiver for the 3-wire ADC configuration
// link. Deserialises 32-bit LSB-first words and mirrors them into a 16x16
// shadow register file that firmware can read back.
// Optional build macro: ADC_RX_HEADER_CHECK_EN -- when defined, words whose
// header field differs from HEADER raise hdr_err and are not written.
module adc_serial_receiver
    import adc_serial_pkg::*;
#(
    parameter logic [11:0] HEADER      = 12'h001,
    parameter int          NUM_REGS    = 16,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        sdata,
    input  logic        select,
    input  logic [3:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        word_valid,
    output logic [31:0] word_data,
    output logic        frame_err,
    output logic        hdr_err,
    output logic [7:0]  word_count
);

    rx_state_t             state_r;
    logic [CNT_BITS-1:0]   bit_cnt_r;
    logic [WORD_BITS-1:0]  shreg_r;
    logic [WORD_BITS-1:0]  word_data_r;
    logic                  word_valid_r;
    logic                  frame_err_r;
    logic                  hdr_err_r;
    logic [7:0]            word_count_r;
    logic [15:0]           rd_data_r;
    logic [15:0]           regs_r [NUM_REGS];

    logic                  sclk_sync_s;
    logic                  sclk_rise_s;
    logic                  sdata_sync_s;
    logic                  sdata_rise_unused_s;
    logic                  sel_sync_s;
    logic                  sel_rise_unused_s;
    logic                  hdr_bad_s;
    logic                  reg_we_s;
    logic [3:0]            wr_addr_s;
    logic [15:0]           wr_data_s;
    logic                  unused_s;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sclk),
        .sync  (sclk_sync_s),
        .rise  (sclk_rise_s)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sdata),
        .sync  (sdata_sync_s),
        .rise  (sdata_rise_unused_s)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_select (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (select),
        .sync  (sel_sync_s),
        .rise  (sel_rise_unused_s)
    );

`ifdef ADC_RX_HEADER_CHECK_EN
    assign hdr_bad_s = (shreg_r[WORD_BITS-1:HDR_LSB] != HEADER);
    assign hdr_err   = hdr_err_r;
    assign unused_s  = &{1'b0, sdata_rise_unused_s, sel_rise_unused_s, sclk_sync_s};
`else
    assign hdr_bad_s = 1'b0;
    assign hdr_err   = 1'b0;
    assign unused_s  = &{1'b0, sdata_rise_unused_s, sel_rise_unused_s, sclk_sync_s,
                         hdr_err_r, ^HEADER};
`endif

    assign wr_addr_s = shreg_r[ADDR_MSB:ADDR_LSB];
    assign wr_data_s = shreg_r[DATA_MSB:0];
    assign reg_we_s  = (state_r == COMMIT) && !hdr_bad_s;

    // Frame FSM: tracks select, shifts bits on sclk rises and commits whole words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= WAIT_IDLE;
            bit_cnt_r    <= 5'd0;
            shreg_r      <= 32'h0000_0000;
            word_data_r  <= 32'h0000_0000;
            word_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            hdr_err_r    <= 1'b0;
            word_count_r <= 8'd0;
        end else begin
            word_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            hdr_err_r    <= 1'b0;
            case (state_r)
                // A frame cut by reset is discarded: wait for select to go idle first.
                WAIT_IDLE: begin
                    if (sel_sync_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_IDLE;
                    end
                end
                IDLE: begin
                    if (!sel_sync_s) begin
                        state_r   <= SHIFT;
                        bit_cnt_r <= 5'd0;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                // The 32nd rise wins over a simultaneous select release.
                SHIFT: begin
                    if (sclk_rise_s && (bit_cnt_r == 5'd31)) begin
                        shreg_r[bit_cnt_r] <= sdata_sync_s;
                        bit_cnt_r          <= 5'd0;
                        state_r            <= COMMIT;
                    end else if (sel_sync_s) begin
                        frame_err_r <= (bit_cnt_r != 5'd0) || sclk_rise_s;
                        bit_cnt_r   <= 5'd0;
                        state_r     <= IDLE;
                    end else if (sclk_rise_s) begin
                        shreg_r[bit_cnt_r] <= sdata_sync_s;
                        bit_cnt_r          <= bit_cnt_r + 5'd1;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                COMMIT: begin
                    word_data_r  <= shreg_r;
                    word_valid_r <= 1'b1;
                    word_count_r <= sat_inc8(word_count_r);
                    hdr_err_r    <= hdr_bad_s;
                    if (sel_sync_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    state_r <= WAIT_IDLE;
                end
            endcase
        end
    end

    // Shadow register file, written once per committed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 16'h0000;
            end
        end else if (reg_we_s) begin
            regs_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Registered read port; a same-cycle write is seen on the following read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= 16'h0000;
        end else begin
            rd_data_r <= regs_r[rd_addr];
        end
    end

    assign rd_data    = rd_data_r;
    assign word_valid = word_valid_r;
    assign word_data  = word_data_r;
    assign frame_err  = frame_err_r;
    assign word_count = word_count_r;

endmodule
